// File: rtl/fifo_read_arbiter_if.sv
// FIFO-side pop bus and merged output stream of the read-side arbiter.
// The master modport is the arbiter's view.
interface fifo_read_arbiter_if #(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int SRC_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

    logic [NUM_FIFOS-1:0]            empty;
    logic [NUM_FIFOS*DATA_WIDTH-1:0] rdata;
    logic [NUM_FIFOS-1:0]            r_en;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [SRC_WIDTH-1:0]            out_src;
    logic                            out_valid;
    logic                            out_ready;

    modport master (
        input  empty, rdata, out_ready,
        output r_en, out_data, out_src, out_valid
    );

    modport slave (
        output empty, rdata, out_ready,
        input  r_en, out_data, out_src, out_valid
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter draining several FWFT FIFOs into one registered
// valid/ready stream. A grant lasts until MAX_BURST pops or its FIFO empties.
module fifo_read_arbiter #(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk_r,
    input  logic                arst,
    fifo_read_arbiter_if.master bus,
    output logic                busy
);
    localparam int SRC_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W:0]   NUM_EXT    = (SRC_W + 1)'(NUM_FIFOS);
    localparam logic [SRC_W-1:0] LAST_RESET = SRC_W'(NUM_FIFOS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [SRC_W-1:0]      grant_reg, grant_next;
    logic [SRC_W-1:0]      last_reg,  last_next;
    logic [CNT_W-1:0]      cnt_reg,   cnt_next;
    logic [DATA_WIDTH-1:0] data_reg,  data_next;
    logic [SRC_W-1:0]      src_reg,   src_next;
    logic                  valid_reg, valid_next;

    logic [DATA_WIDTH-1:0] word     [NUM_FIFOS];
    logic [SRC_W-1:0]      cand_idx [NUM_FIFOS];
    logic [NUM_FIFOS-1:0]  cand_ok;
    logic [SRC_W-1:0]      sel_idx;
    logic                  any_ready;
    logic                  grant_empty;
    logic                  out_free;
    logic                  pop;
    logic                  burst_done;
    logic [NUM_FIFOS-1:0]  r_en_next;

    // Candidate gi is the FIFO (gi+1) places after the last grant, wrapped
    // without requiring NUM_FIFOS to be a power of two.
    for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
        logic [SRC_W:0] sum;

        assign word[gi]     = bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign sum          = {1'b0, last_reg} + (SRC_W + 1)'(gi + 1);
        assign cand_idx[gi] = (sum >= NUM_EXT) ? SRC_W'(sum - NUM_EXT) : sum[SRC_W-1:0];
        assign cand_ok[gi]  = ~bus.empty[cand_idx[gi]];
    end

    // Scanning from the far end down leaves the nearest non-empty candidate.
    always_comb begin
        sel_idx = cand_idx[0];
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
            if (cand_ok[k]) begin
                sel_idx = cand_idx[k];
            end
        end
    end

    assign any_ready   = |(~bus.empty);
    assign grant_empty = bus.empty[grant_reg];
    assign out_free    = ~valid_reg | bus.out_ready;
    assign pop         = (state_reg == BURST) & ~grant_empty & out_free;
    assign burst_done  = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_ready) begin
                    grant_next = sel_idx;
                    cnt_next   = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (grant_empty) begin
                    state_next = IDLE;
                    last_next  = grant_reg;
                end else if (pop) begin
                    if (burst_done) begin
                        state_next = IDLE;
                        last_next  = grant_reg;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A pop refills the output register in the same edge the old word leaves.
    always_comb begin
        data_next  = data_reg;
        src_next   = src_reg;
        valid_next = valid_reg;
        if (pop) begin
            data_next  = word[grant_reg];
            src_next   = grant_reg;
            valid_next = 1'b1;
        end else if (bus.out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_comb begin
        r_en_next = '0;
        if (pop) begin
            r_en_next[grant_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk_r or posedge arst) begin
        if (arst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= LAST_RESET;
            cnt_reg   <= '0;
            data_reg  <= '0;
            src_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            src_reg   <= src_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.r_en      = r_en_next;
    assign bus.out_data  = data_reg;
    assign bus.out_src   = src_reg;
    assign bus.out_valid = valid_reg;
    assign busy          = (state_reg == BURST);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: two builds (MAX_BURST 4 and 1) fed by queue-based
// FWFT FIFOs, checked every cycle against a grant/word-count model.
module tb_fifo_read_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int NI = 2;

    logic clk_r = 1'b0;
    logic arst;
    always #5 clk_r = ~clk_r;

    fifo_read_arbiter_if #(.NUM_FIFOS(N), .DATA_WIDTH(DW)) bus_a ();
    fifo_read_arbiter_if #(.NUM_FIFOS(N), .DATA_WIDTH(DW)) bus_b ();
    logic busy_a, busy_b;

    fifo_read_arbiter #(.NUM_FIFOS(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut_a (
        .clk_r(clk_r), .arst(arst), .bus(bus_a.master), .busy(busy_a)
    );
    fifo_read_arbiter #(.NUM_FIFOS(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
        .clk_r(clk_r), .arst(arst), .bus(bus_b.master), .busy(busy_b)
    );

    logic [N-1:0]    empty_drv [NI];
    logic [N*DW-1:0] rdata_drv [NI];
    logic            ready_drv [NI];

    assign bus_a.empty     = empty_drv[0];
    assign bus_a.rdata     = rdata_drv[0];
    assign bus_a.out_ready = ready_drv[0];
    assign bus_b.empty     = empty_drv[1];
    assign bus_b.rdata     = rdata_drv[1];
    assign bus_b.out_ready = ready_drv[1];

    logic [N-1:0]  obs_ren   [NI];
    logic          obs_valid [NI];
    logic [DW-1:0] obs_data  [NI];
    logic [SW-1:0] obs_src   [NI];
    logic          obs_busy  [NI];

    assign obs_ren[0]   = bus_a.r_en;
    assign obs_valid[0] = bus_a.out_valid;
    assign obs_data[0]  = bus_a.out_data;
    assign obs_src[0]   = bus_a.out_src;
    assign obs_busy[0]  = busy_a;
    assign obs_ren[1]   = bus_b.r_en;
    assign obs_valid[1] = bus_b.out_valid;
    assign obs_data[1]  = bus_b.out_data;
    assign obs_src[1]   = bus_b.out_src;
    assign obs_busy[1]  = busy_b;

    logic [DW-1:0] q    [NI*N][$];
    int            pops [NI*N];

    bit            m_busy  [NI];
    int            m_grant [NI];
    int            m_last  [NI];
    int            m_cnt   [NI];
    bit            m_valid [NI];
    logic [DW-1:0] m_data  [NI];
    int            m_src   [NI];

    int            log_src  [NI][$];
    logic [DW-1:0] log_data [NI][$];
    int            log_cyc  [NI][$];

    int compared   = 0;
    int mismatched = 0;
    int cyc_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int max_burst(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic void refresh(int k);
        for (int i = 0; i < N; i++) begin
            empty_drv[k][i]          = (q[k*N+i].size() == 0);
            rdata_drv[k][i*DW +: DW] = (q[k*N+i].size() == 0) ? 8'hEE : q[k*N+i][0];
        end
    endfunction

    function automatic void push(int k, int i, logic [DW-1:0] v);
        q[k*N+i].push_back(v);
    endfunction

    function automatic void clear_logs();
        for (int k = 0; k < NI; k++) begin
            log_src[k].delete();
            log_data[k].delete();
            log_cyc[k].delete();
        end
    endfunction

    function automatic void model_reset(int k);
        m_busy[k]  = 1'b0;
        m_grant[k] = 0;
        m_last[k]  = N - 1;
        m_cnt[k]   = 0;
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
        m_src[k]   = 0;
    endfunction

    // A grant holds a FIFO until max_burst words have been taken from it or it
    // shows empty; an idle edge only picks the next non-empty FIFO in rotation.
    function automatic void model_step(int k, logic [N-1:0] e, logic [N*DW-1:0] d, logic rdy);
        bit was_idle;
        bit take;
        bit found;
        int c;
        was_idle = !m_busy[k];
        take = m_busy[k] && !e[m_grant[k]] && (!m_valid[k] || rdy);
        if (take) begin
            m_valid[k] = 1'b1;
            m_data[k]  = d[m_grant[k]*DW +: DW];
            m_src[k]   = m_grant[k];
            m_cnt[k]   = m_cnt[k] + 1;
            if (m_cnt[k] == max_burst(k)) begin
                m_busy[k] = 1'b0;
                m_last[k] = m_grant[k];
            end
        end else begin
            if (rdy) m_valid[k] = 1'b0;
            if (m_busy[k] && e[m_grant[k]]) begin
                m_busy[k] = 1'b0;
                m_last[k] = m_grant[k];
            end
        end
        if (was_idle) begin
            found = 1'b0;
            for (int j = 1; j <= N; j++) begin
                c = (m_last[k] + j) % N;
                if (!found && !e[c]) begin
                    found      = 1'b1;
                    m_busy[k]  = 1'b1;
                    m_grant[k] = c;
                    m_cnt[k]   = 0;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ren(int k);
        logic [N-1:0] r;
        r = '0;
        if (m_busy[k] && !empty_drv[k][m_grant[k]] && (!m_valid[k] || ready_drv[k]))
            r[m_grant[k]] = 1'b1;
        return r;
    endfunction

    // One clock: compare at the falling edge, then advance model and FIFOs
    // just after the rising edge.
    task automatic cycle();
        logic [N-1:0]    e_s   [NI];
        logic [N*DW-1:0] d_s   [NI];
        logic            r_s   [NI];
        logic [N-1:0]    ren_s [NI];
        @(negedge clk_r);
        cyc_count++;
        for (int k = 0; k < NI; k++) begin
            e_s[k]   = empty_drv[k];
            d_s[k]   = rdata_drv[k];
            r_s[k]   = ready_drv[k];
            ren_s[k] = obs_ren[k];
            if (!arst) begin
                check($sformatf("r_en[%0d]", k), 32'(obs_ren[k]), 32'(exp_ren(k)));
                check($sformatf("out_valid[%0d]", k), 32'(obs_valid[k]), 32'(m_valid[k]));
                check($sformatf("busy[%0d]", k), 32'(obs_busy[k]), 32'(m_busy[k]));
                if (m_valid[k]) begin
                    check($sformatf("out_data[%0d]", k), 32'(obs_data[k]), 32'(m_data[k]));
                    check($sformatf("out_src[%0d]", k), 32'(obs_src[k]), 32'(m_src[k]));
                end
                if (obs_valid[k] && ready_drv[k]) begin
                    log_src[k].push_back(int'(obs_src[k]));
                    log_data[k].push_back(obs_data[k]);
                    log_cyc[k].push_back(cyc_count);
                    $display("xfer dut=%0d cycle=%0d src=%0d data=%02h", k, cyc_count, obs_src[k], obs_data[k]);
                end
            end
        end
        @(posedge clk_r);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (arst) model_reset(k);
            else      model_step(k, e_s[k], d_s[k], r_s[k]);
            for (int i = 0; i < N; i++) begin
                if (!arst && ren_s[k][i] && q[k*N+i].size() > 0) begin
                    void'(q[k*N+i].pop_front());
                    pops[k*N+i]++;
                end
            end
            refresh(k);
        end
    endtask

    task automatic check_log(input string name, input int k, input int idx, input int src, input int data);
        if (idx < log_src[k].size()) begin
            check($sformatf("%s_src[%0d]", name, idx), 32'(log_src[k][idx]), 32'(src));
            check($sformatf("%s_data[%0d]", name, idx), 32'(log_data[k][idx]), 32'(data));
        end else begin
            check($sformatf("%s_count", name), 32'(log_src[k].size()), 32'(idx + 1));
        end
    endtask

    int  rise;
    int  budget;
    bit  done;
    int  idx;
    int  bad;

    initial begin
        arst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            ready_drv[k] = 1'b1;
            model_reset(k);
            refresh(k);
        end
        for (int i = 0; i < NI*N; i++) pops[i] = 0;
        repeat (3) cycle();
        check("rst_valid", 32'(obs_valid[0]), 32'd0);
        check("rst_busy",  32'(obs_busy[0]),  32'd0);
        check("rst_ren",   32'(obs_ren[0]),   32'd0);
        check("rst_data",  32'(obs_data[0]),  32'd0);
        check("rst_src",   32'(obs_src[0]),   32'd0);
        arst = 1'b0;
        repeat (2) cycle();

        // Single source: FIFO 1 holds three words.
        clear_logs();
        push(0, 1, 8'h11); push(0, 1, 8'h12); push(0, 1, 8'h13);
        refresh(0);
        rise = -1;
        for (int c = 1; c <= 7; c++) begin
            cycle();
            if (rise < 0 && obs_valid[0]) rise = c;
        end
        check("single_latency", 32'(rise), 32'd2);
        check_log("single", 0, 0, 1, 8'h11);
        check_log("single", 0, 1, 1, 8'h12);
        check_log("single", 0, 2, 1, 8'h13);
        check("single_count", 32'(log_src[0].size()), 32'd3);
        if (log_cyc[0].size() == 3)
            check("single_back2back", 32'(log_cyc[0][2] - log_cyc[0][0]), 32'd2);
        check("single_idle", 32'(obs_busy[0]), 32'd0);

        // Backpressure: hold the first word for five cycles.
        clear_logs();
        push(0, 0, 8'hA0); push(0, 0, 8'hA1);
        refresh(0);
        cycle(); cycle();
        check("bp_first_valid", 32'(obs_valid[0]), 32'd1);
        check("bp_first_data",  32'(obs_data[0]),  32'hA0);
        ready_drv[0] = 1'b0;
        repeat (5) begin
            cycle();
            #1;
            check("bp_hold_data", 32'(obs_data[0]), 32'hA0);
            check("bp_hold_ren",  32'(obs_ren[0]),  32'd0);
        end
        ready_drv[0] = 1'b1;
        cycle();
        check("bp_next_valid", 32'(obs_valid[0]), 32'd1);
        check("bp_next_data",  32'(obs_data[0]),  32'hA1);
        repeat (4) cycle();
        check_log("bp", 0, 0, 0, 8'hA0);
        check_log("bp", 0, 1, 0, 8'hA1);

        // Round-robin wrap: make FIFO 3 the last grant, then offer 0 and 3.
        push(0, 3, 8'h3C);
        refresh(0);
        repeat (5) cycle();
        clear_logs();
        push(0, 0, 8'h0D); push(0, 3, 8'h3D);
        refresh(0);
        repeat (8) cycle();
        check("wrap_count", 32'(log_src[0].size()), 32'd2);
        check_log("wrap", 0, 0, 0, 8'h0D);
        check_log("wrap", 0, 1, 3, 8'h3D);

        // Fairness: ten words in every FIFO.
        clear_logs();
        for (int i = 0; i < N*NI; i++) pops[i] = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 10; j++) push(0, i, DW'(i*16 + j));
        refresh(0);
        budget = 0;
        done   = 1'b0;
        while (!done && budget < 200) begin
            cycle();
            budget++;
            done = !obs_busy[0] && !obs_valid[0];
            for (int i = 0; i < N; i++) if (q[i].size() != 0) done = 1'b0;
        end
        check("fair_finished", 32'(done), 32'd1);
        check("fair_count", 32'(log_src[0].size()), 32'd40);
        idx = 0;
        for (int r = 0; r < 3; r++)
            for (int f = 0; f < N; f++)
                for (int j = 0; j < ((r < 2) ? 4 : 2); j++) begin
                    check_log("fair", 0, idx, f, f*16 + r*4 + j);
                    idx++;
                end
        bad = 0;
        for (int n = 1; n <= 32 && n < log_cyc[0].size(); n++)
            if (log_cyc[0][n] - log_cyc[0][n-1] != ((n % 4 == 0) ? 2 : 1)) bad++;
        check("fair_spacing", 32'(bad), 32'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("fair_pops[%0d]", i), 32'(pops[i]), 32'd10);

        // MAX_BURST=1 build: FIFOs 0 and 1 alternate one word per grant.
        clear_logs();
        push(1, 0, 8'h50); push(1, 0, 8'h51);
        push(1, 1, 8'h60); push(1, 1, 8'h61);
        refresh(1);
        repeat (12) cycle();
        check("mb1_count", 32'(log_src[1].size()), 32'd4);
        check_log("mb1", 1, 0, 0, 8'h50);
        check_log("mb1", 1, 1, 1, 8'h60);
        check_log("mb1", 1, 2, 0, 8'h51);
        check_log("mb1", 1, 3, 1, 8'h61);
        if (log_cyc[1].size() == 4)
            check("mb1_spacing", 32'(log_cyc[1][3] - log_cyc[1][0]), 32'd6);

        // Asynchronous reset in the middle of a burst.
        push(0, 1, 8'h71); push(0, 1, 8'h72); push(0, 1, 8'h73); push(0, 1, 8'h74);
        push(0, 2, 8'h81); push(0, 2, 8'h82); push(0, 2, 8'h83);
        refresh(0);
        repeat (3) cycle();
        check("pre_rst_busy",  32'(obs_busy[0]),  32'd1);
        check("pre_rst_valid", 32'(obs_valid[0]), 32'd1);
        #2;
        arst = 1'b1;
        #1;
        check("arst_ren",   32'(obs_ren[0]),   32'd0);
        check("arst_valid", 32'(obs_valid[0]), 32'd0);
        check("arst_busy",  32'(obs_busy[0]),  32'd0);
        for (int i = 0; i < N*NI; i++) q[i].delete();
        refresh(0);
        refresh(1);
        cycle();
        arst = 1'b0;
        clear_logs();
        push(0, 2, 8'h21); push(0, 2, 8'h22);
        refresh(0);
        repeat (6) cycle();
        check("post_rst_count", 32'(log_src[0].size()), 32'd2);
        check_log("post_rst", 0, 0, 2, 8'h21);
        check_log("post_rst", 0, 1, 2, 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
